// File: rtl/t05_cb_sequencer.sv
// Codebook-phase sequencer: fetches 71-bit tree elements as three SRAM words and hands found characters to the SPI writer.
// Optional SRAM ack watchdog enabled by defining CB_SEQ_TIMEOUT_EN.
module t05_cb_sequencer #(
  parameter logic [31:0] HTREE_BASE     = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    en_state,
  input  logic [6:0]    cb_index,
  input  logic          cb_char_found,
  input  logic [7:0]    cb_char_index,
  input  logic [127:0]  cb_char_path,
  input  logic [3:0]    cb_finished,
  output logic [70:0]   h_element,
  output logic          SRAM_enable,
  output logic          write_finish,
  output logic          sram_req,
  output logic [31:0]   sram_addr,
  input  logic [31:0]   sram_rdata,
  input  logic          sram_ack,
  output logic          wr_valid,
  output logic [7:0]    wr_char,
  output logic [127:0]  wr_path,
  output logic [6:0]    wr_len,
  input  logic          wr_ready,
  output logic          done,
  output logic          err
);

  localparam int unsigned ELEM_W = 71;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned PATH_W = 128;
  localparam int unsigned LEN_W  = 7;
  localparam int unsigned WCNT_W = 2;

  localparam logic [3:0] EN_CODEBOOK = 4'd4;
  localparam logic [3:0] FIN_DONE    = 4'b0101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_ACKWAIT,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 vld_q, vld_d;
  logic [IDX_W-1:0]     tag_q, tag_d;
  logic [WCNT_W-1:0]    w_q, w_d;
  logic [ELEM_W-1:0]    elem_q, elem_d;
  logic                 sram_req_q, sram_req_d;
  logic [31:0]          sram_addr_q, sram_addr_d;
  logic                 wr_valid_q, wr_valid_d;
  logic [7:0]           wr_char_q, wr_char_d;
  logic [PATH_W-1:0]    wr_path_q, wr_path_d;
  logic [LEN_W-1:0]     wr_len_q, wr_len_d;
  logic                 write_finish_q, write_finish_d;
  logic                 done_q, done_d;
  logic                 active;

`ifdef CB_SEQ_TIMEOUT_EN
  logic [7:0]           tmo_cnt_q, tmo_cnt_d;
  logic                 err_q, err_d;
`else
  logic                 unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Path length is the position of the leading control 1.
  function automatic logic [LEN_W-1:0] msb_pos(input logic [PATH_W-1:0] p);
    logic [LEN_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(PATH_W); i++) begin
      if (p[i]) r = LEN_W'(i);
    end
    return r;
  endfunction

  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] t, input logic [WCNT_W-1:0] w);
    return HTREE_BASE + ((32'(t) * 32'd3 + 32'(w)) << 2);
  endfunction

  assign active = (en_state == EN_CODEBOOK);

  always_comb begin
    state_d   = state_q;
    vld_d     = vld_q;
    tag_d     = tag_q;
    w_d       = w_q;
    elem_d    = elem_q;
    wr_char_d = wr_char_q;
    wr_path_d = wr_path_q;
    wr_len_d  = wr_len_q;
`ifdef CB_SEQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (active) begin
          if (cb_finished == FIN_DONE) begin
            state_d = S_DONE;
          end else if (cb_char_found) begin
            wr_char_d = cb_char_index;
            wr_path_d = cb_char_path;
            wr_len_d  = msb_pos(cb_char_path);
            state_d   = S_SEND;
          end else if (!vld_q || tag_q != cb_index) begin
            vld_d   = 1'b0;
            tag_d   = cb_index;
            w_d     = '0;
            state_d = S_FETCH;
`ifdef CB_SEQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
      end

      S_FETCH: begin
        if (sram_ack) begin
          unique case (w_q)
            2'd0:    elem_d[31:0]  = sram_rdata;
            2'd1:    elem_d[63:32] = sram_rdata;
            default: elem_d[70:64] = sram_rdata[6:0];
          endcase
`ifdef CB_SEQ_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
          if (w_q == 2'd2) begin
            vld_d   = active;
            w_d     = '0;
            state_d = S_IDLE;
          end else if (!active) begin
            // Phase left mid-element: drop the partial element after this word.
            vld_d   = 1'b0;
            w_d     = '0;
            state_d = S_IDLE;
          end else begin
            w_d = w_q + 2'd1;
          end
        end
`ifdef CB_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TIMEOUT_CYCLES - 8'd1) begin
          err_d     = 1'b1;
          tmo_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end

      S_SEND: begin
        if (active && wr_ready) state_d = S_ACKWAIT;
      end

      S_ACKWAIT: begin
        // The walker backtracks after a write, so the cached element is stale.
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end

      S_DONE: state_d = S_DONE;

      default: state_d = S_IDLE;
    endcase

    // Registered status outputs track the state being entered.
    sram_req_d     = (state_d == S_FETCH);
    sram_addr_d    = sram_req_d ? word_addr(tag_d, w_d) : 32'd0;
    wr_valid_d     = (state_d == S_SEND);
    write_finish_d = (state_d == S_ACKWAIT);
    done_d         = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      vld_q          <= 1'b0;
      tag_q          <= '0;
      w_q            <= '0;
      elem_q         <= '0;
      sram_req_q     <= 1'b0;
      sram_addr_q    <= '0;
      wr_valid_q     <= 1'b0;
      wr_char_q      <= '0;
      wr_path_q      <= '0;
      wr_len_q       <= '0;
      write_finish_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      vld_q          <= vld_d;
      tag_q          <= tag_d;
      w_q            <= w_d;
      elem_q         <= elem_d;
      sram_req_q     <= sram_req_d;
      sram_addr_q    <= sram_addr_d;
      wr_valid_q     <= wr_valid_d;
      wr_char_q      <= wr_char_d;
      wr_path_q      <= wr_path_d;
      wr_len_q       <= wr_len_d;
      write_finish_q <= write_finish_d;
      done_q         <= done_d;
    end
  end

`ifdef CB_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Cache hit is combinational so it drops in the same cycle cb_index moves.
  assign SRAM_enable  = vld_q && (tag_q == cb_index) && (state_q == S_IDLE);
  assign h_element    = elem_q;
  assign sram_req     = sram_req_q;
  assign sram_addr    = sram_addr_q;
  assign wr_valid     = wr_valid_q;
  assign wr_char      = wr_char_q;
  assign wr_path      = wr_path_q;
  assign wr_len       = wr_len_q;
  assign write_finish = write_finish_q;
  assign done         = done_q;

endmodule

// File: tb/tb_t05_cb_sequencer.sv
// Scoreboard bench for t05_cb_sequencer: expected SRAM addresses, elements and write records are queued
// by the stimulus and consumed by monitor processes.
module tb_t05_cb_sequencer;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    en_state;
  logic [6:0]    cb_index;
  logic          cb_char_found;
  logic [7:0]    cb_char_index;
  logic [127:0]  cb_char_path;
  logic [3:0]    cb_finished;
  logic [70:0]   h_element;
  logic          SRAM_enable;
  logic          write_finish;
  logic          sram_req;
  logic [31:0]   sram_addr;
  logic [31:0]   sram_rdata;
  logic          sram_ack;
  logic          wr_valid;
  logic [7:0]    wr_char;
  logic [127:0]  wr_path;
  logic [6:0]    wr_len;
  logic          wr_ready;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  t05_cb_sequencer #(
    .HTREE_BASE     (32'h0000_0000),
    .TIMEOUT_CYCLES (8'd10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en_state      (en_state),
    .cb_index      (cb_index),
    .cb_char_found (cb_char_found),
    .cb_char_index (cb_char_index),
    .cb_char_path  (cb_char_path),
    .cb_finished   (cb_finished),
    .h_element     (h_element),
    .SRAM_enable   (SRAM_enable),
    .write_finish  (write_finish),
    .sram_req      (sram_req),
    .sram_addr     (sram_addr),
    .sram_rdata    (sram_rdata),
    .sram_ack      (sram_ack),
    .wr_valid      (wr_valid),
    .wr_char       (wr_char),
    .wr_path       (wr_path),
    .wr_len        (wr_len),
    .wr_ready      (wr_ready),
    .done          (done),
    .err           (err)
  );

  typedef struct {
    logic [7:0]   ch;
    logic [127:0] path;
    logic [6:0]   len;
  } wr_rec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [70:0] exp_elem_q[$];
  wr_rec_t     exp_wr_q[$];
  int          wait_cycles = 0;
  bit          respond_en = 1'b0;
  int          wf_count = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // SRAM image: upper half constant so the discarded bits of word 2 are non-zero.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hD0D0, a[15:0]};
  endfunction

  // SRAM responder: acks after wait_cycles idle cycles and checks the address of each acked read.
  initial begin
    int cnt;
    cnt = 0;
    sram_ack = 1'b0;
    sram_rdata = '0;
    forever begin
      @(negedge clk);
      sram_ack = 1'b0;
      if (sram_req && !rst && respond_en) begin
        if (cnt >= wait_cycles) begin
          sram_ack = 1'b1;
          sram_rdata = mem_word(sram_addr);
          cnt = 0;
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sram_addr_unexpected actual=%0h required=none", sram_addr);
          end else begin
            check("sram_addr", 128'(sram_addr), 128'(exp_addr_q.pop_front()));
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Output monitor: element on each SRAM_enable rise, record on each accepted write.
  initial begin
    logic prev_en;
    wr_rec_t r;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (SRAM_enable && !prev_en) begin
        if (exp_elem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL h_element_unexpected actual=%0h required=none", h_element);
        end else begin
          check("h_element", 128'(h_element), 128'(exp_elem_q.pop_front()));
        end
      end
      prev_en = SRAM_enable;
      if (wr_valid && wr_ready) begin
        if (exp_wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_record_unexpected actual=%0h required=none", wr_char);
        end else begin
          r = exp_wr_q.pop_front();
          check("wr_char", 128'(wr_char), 128'(r.ch));
          check("wr_path", wr_path, r.path);
          check("wr_len", 128'(wr_len), 128'(r.len));
        end
      end
      if (write_finish) wf_count++;
    end
  end

  // Issue a miss on idx and time the element becoming valid (sampled #1 after each negedge).
  task automatic do_fetch(input logic [6:0] idx, input logic [31:0] a0, input int exp_cyc);
    int cyc;
    @(negedge clk);
    en_state = 4'd4;
    cb_index = idx;
    #1;
    check("enable_low_on_miss", 128'(SRAM_enable), 128'(0));
    @(negedge clk);
    #1;
    check("req_after_miss", 128'(sram_req), 128'(1));
    check("first_addr", 128'(sram_addr), 128'(a0));
    cyc = 1;
    while (!SRAM_enable && cyc < 60) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("miss_to_enable_cycles", 128'(cyc), 128'(exp_cyc));
  endtask

  initial begin
    wr_rec_t rec;
    int cyc;
    rst = 1'b1;
    en_state = 4'd0;
    cb_index = 7'd0;
    cb_char_found = 1'b0;
    cb_char_index = 8'd0;
    cb_char_path = '0;
    cb_finished = 4'd0;
    wr_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_sram_req", 128'(sram_req), 128'(0));
    check("rst_sram_addr", 128'(sram_addr), 128'(0));
    check("rst_h_element", 128'(h_element), 128'(0));
    check("rst_wr_outs", {wr_path[119:0], wr_char}, 128'(0));
    check("rst_flags", 128'({wr_valid, wr_len, write_finish, done, err, SRAM_enable}), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    // Index 5 with two wait cycles per word.
    wait_cycles = 2;
    respond_en = 1'b1;
    exp_addr_q.push_back(32'h3C);
    exp_addr_q.push_back(32'h40);
    exp_addr_q.push_back(32'h44);
    exp_elem_q.push_back({7'h44, 32'hD0D0_0040, 32'hD0D0_003C});
    do_fetch(7'd5, 32'h3C, 10);
    @(negedge clk);
    #1;
    check("enable_hit_idx5", 128'(SRAM_enable), 128'(1));

    // Index change 5 -> 9 drops SRAM_enable in the same cycle and refetches.
    exp_addr_q.push_back(32'h6C);
    exp_addr_q.push_back(32'h70);
    exp_addr_q.push_back(32'h74);
    exp_elem_q.push_back({7'h74, 32'hD0D0_0070, 32'hD0D0_006C});
    do_fetch(7'd9, 32'h6C, 10);

    // Character send; the cache is invalidated so index 9 is refetched with zero-wait acks.
    wait_cycles = 0;
    rec.ch = 8'h41;
    rec.path = 128'b1011;
    rec.len = 7'd3;
    exp_wr_q.push_back(rec);
    exp_addr_q.push_back(32'h6C);
    exp_addr_q.push_back(32'h70);
    exp_addr_q.push_back(32'h74);
    exp_elem_q.push_back({7'h74, 32'hD0D0_0070, 32'hD0D0_006C});
    @(negedge clk);
    cb_char_found = 1'b1;
    cb_char_index = 8'h41;
    cb_char_path = 128'b1011;
    @(negedge clk);
    cb_char_found = 1'b0;
    #1;
    check("wr_valid_next_cycle", 128'(wr_valid), 128'(1));
    check("wr_len_registered", 128'(wr_len), 128'(3));
    repeat (3) @(negedge clk);
    #1;
    check("wr_valid_held", 128'(wr_valid), 128'(1));
    @(negedge clk);
    wr_ready = 1'b1;
    @(negedge clk);
    wr_ready = 1'b0;
    #1;
    check("write_finish_pulse", 128'({write_finish, wr_valid}), 128'(2'b10));
    @(negedge clk);
    #1;
    check("write_finish_one_cycle", 128'(write_finish), 128'(0));
    check("vld_cleared_after_write", 128'(SRAM_enable), 128'(0));
    cyc = 0;
    while (!SRAM_enable && cyc < 60) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("zero_wait_miss_latency", 128'(cyc), 128'(4));
    check("write_finish_count", 128'(wf_count), 128'(1));

    // Finish and char_found together: DONE wins, no write, no fetch.
    @(negedge clk);
    cb_finished = 4'b0101;
    cb_char_found = 1'b1;
    cb_index = 7'd20;
    wr_ready = 1'b1;
    @(negedge clk);
    cb_char_found = 1'b0;
    #1;
    check("done_on_finish", 128'({done, wr_valid, sram_req}), 128'(3'b100));
    repeat (5) @(negedge clk);
    #1;
    check("done_held", 128'({done, wr_valid, sram_req}), 128'(3'b100));
    wr_ready = 1'b0;

    // Reset mid-fetch, no acks.
    @(negedge clk);
    rst = 1'b1;
    cb_finished = 4'd0;
    respond_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    en_state = 4'd4;
    cb_index = 7'd3;
    @(negedge clk);
    #1;
    check("fetch_before_reset", 128'({sram_req, sram_addr}), 128'({1'b1, 32'h24}));
    @(negedge clk);
    rst = 1'b1;
    en_state = 4'd0;
    #1;
    check("req_held_until_edge", 128'(sram_req), 128'(1));
    @(negedge clk);
    #1;
    check("rst_mid_fetch_req", 128'({sram_req, sram_addr}), 128'(0));
    check("rst_mid_fetch_state", 128'({h_element, done, wr_valid, write_finish, SRAM_enable}), 128'(0));
    @(negedge clk);
    #1;
    check("rst_second_cycle", 128'({sram_req, done, err}), 128'(0));
    rst = 1'b0;

    // Ack watchdog: no acks for index 7.
    @(negedge clk);
    en_state = 4'd4;
    cb_index = 7'd7;
    repeat (10) @(negedge clk);
    #1;
    check("fetch_before_timeout", 128'({err, done, sram_req}), 128'(3'b001));
    @(negedge clk);
    #1;
`ifdef CB_SEQ_TIMEOUT_EN
    check("timeout_err_done", 128'({err, done, sram_req}), 128'(3'b110));
`else
    check("no_timeout_waits", 128'({err, done, sram_req}), 128'(3'b001));
`endif

    check("addr_queue_drained", 128'(exp_addr_q.size()), 128'(0));
    check("elem_queue_drained", 128'(exp_elem_q.size()), 128'(0));
    check("wr_queue_drained", 128'(exp_wr_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
